// File: rtl/multiply_accumulate_unit_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification helpers
// for the iterative multiply-accumulate unit.
package multiply_accumulate_unit_pkg;

  localparam logic [3:0] OP_MUL   = 4'b0000;
  localparam logic [3:0] OP_MLA   = 4'b0001;
  localparam logic [3:0] OP_UMULL = 4'b0100;
  localparam logic [3:0] OP_UMLAL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_SMLAL = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MLA, OP_UMULL, OP_UMLAL, OP_SMULL, OP_SMLAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_long(input logic [3:0] op);
    case (op)
      OP_UMULL, OP_UMLAL, OP_SMULL, OP_SMLAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_SMULL) || (op == OP_SMLAL);
  endfunction

  function automatic logic op_is_accum(input logic [3:0] op);
    return (op == OP_MLA) || (op == OP_UMLAL) || (op == OP_SMLAL);
  endfunction

endpackage

// File: rtl/multiply_accumulate_unit_mac_step.sv
// One radix-2^STEP iteration: adds STEP multiplier bits times the
// multiplicand into the running double-width sum.
module mac_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic [2*WIDTH-1:0] i_sum,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [STEP-1:0]    i_bits,
  output logic [2*WIDTH-1:0] o_sum
);

  always_comb begin
    o_sum = i_sum;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i_bits[i]) begin
        o_sum = o_sum + (i_mcand << i);
      end
    end
  end

endmodule

// File: rtl/multiply_accumulate_unit.sv
// Iterative multiply / multiply-accumulate unit retiring STEP multiplier bits
// per cycle; signed ops run on magnitudes and fix the sign at the end.
module multiply_accumulate_unit
  import multiply_accumulate_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_n,
  output logic               flag_z,
  output logic               err
);

  localparam int unsigned ITER  = WIDTH / STEP;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t               r_state;
  logic [3:0]           r_op;
  logic [2*WIDTH-1:0]   r_sum;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_flag_n;
  logic                 r_flag_z;
  logic                 r_err;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_acc_in;
  logic [2*WIDTH-1:0]   w_step_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_total;
  logic                 w_long;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_n;
  logic                 w_z;

  // Most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    w_signed = op_is_signed(opcode);
    w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;
    w_acc_in = '0;
    if (op_is_accum(opcode)) begin
      w_acc_in = op_is_long(opcode) ? {c, d} : {{WIDTH{1'b0}}, c};
    end
  end

  mac_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_mac_step (
    .i_sum   (r_sum),
    .i_mcand (r_mcand),
    .i_bits  (r_mplier[STEP-1:0]),
    .o_sum   (w_step_sum)
  );

  always_comb begin
    w_prod  = r_neg ? -w_step_sum : w_step_sum;
    w_total = w_prod + r_acc;
    w_long  = op_is_long(r_op);
    w_res   = w_long ? w_total : {{WIDTH{1'b0}}, w_total[WIDTH-1:0]};
    w_n     = w_long ? w_total[2*WIDTH-1] : w_total[WIDTH-1];
    w_z     = w_long ? (w_total == '0) : (w_total[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_op <= opcode;
            if (op_is_valid(opcode)) begin
              r_state  <= ST_RUN;
              r_sum    <= '0;
              r_cnt    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
              r_mplier <= w_mag_b;
              r_neg    <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_acc    <= w_acc_in;
            end else begin
              r_state  <= ST_DONE;
              r_result <= '0;
              r_flag_n <= 1'b0;
              r_flag_z <= 1'b0;
              r_err    <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sum    <= w_step_sum;
          r_mcand  <= r_mcand << STEP;
          r_mplier <= r_mplier >> STEP;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state  <= ST_DONE;
            r_cnt    <= '0;
            r_result <= w_res;
            r_flag_n <= w_n;
            r_flag_z <= w_z;
            r_err    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready  = (r_state != ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign flag_n = r_flag_n;
  assign flag_z = r_flag_z;
  assign err    = r_err;

endmodule

// File: tb/tb_multiply_accumulate_unit.sv
// Scoreboard bench for multiply_accumulate_unit: stimulus queues expected
// completions and status snapshots, a negedge monitor pops and compares.
module tb_multiply_accumulate_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] a, b, c, d;
  logic        ready, done, flag_n, flag_z, err;
  logic [63:0] result;

  multiply_accumulate_unit #(
    .WIDTH (32),
    .STEP  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .ready  (ready),
    .done   (done),
    .result (result),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .err    (err)
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [63:0] res;
    logic        n, z, e;
  } exp_t;

  typedef struct {
    string       tag;
    int          cyc;
    logic        rdy, dn;
    logic [63:0] res;
    logic        n, z, e;
  } st_t;

  exp_t sb[$];
  st_t  st_q[$];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  logic finish_req = 1'b0;

  logic [63:0] last_res = '0;
  logic        last_n = 1'b0, last_z = 1'b0, last_e = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb.size() != 0 && !done && cyc > sb[0].cyc) begin
      exp_t m;
      m = sb.pop_front();
      n_checks++;
      n_errs++;
      $display("FAIL %s missing done: expected at cycle %0d, now %0d", m.tag, m.cyc, cyc);
    end
    if (done) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errs++;
        $display("FAIL unexpected_done at cycle %0d result=%h", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc || result !== e.res || flag_n !== e.n || flag_z !== e.z || err !== e.e) begin
          n_errs++;
          $display("FAIL %s got cyc=%0d res=%h n=%b z=%b err=%b, want cyc=%0d res=%h n=%b z=%b err=%b",
                   e.tag, cyc, result, flag_n, flag_z, err, e.cyc, e.res, e.n, e.z, e.e);
        end
      end
    end
    if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
      st_t s;
      s = st_q.pop_front();
      n_checks++;
      if (ready !== s.rdy || done !== s.dn || result !== s.res || flag_n !== s.n ||
          flag_z !== s.z || err !== s.e) begin
        n_errs++;
        $display("FAIL %s got rdy=%b done=%b res=%h n=%b z=%b err=%b, want rdy=%b done=%b res=%h n=%b z=%b err=%b",
                 s.tag, ready, done, result, flag_n, flag_z, err, s.rdy, s.dn, s.res, s.n, s.z, s.e);
      end
    end
    if (finish_req) begin
      n_checks++;
      if (sb.size() != 0 || st_q.size() != 0) begin
        n_errs++;
        $display("FAIL leftover_expectations got sb=%0d st=%0d, want 0/0", sb.size(), st_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no end of test, want completion");
    $fatal(1);
  end

  // Called at a negedge; leaves the bench at the following negedge with start low.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] ia, ib, ic, id,
                       input logic push, input int lat, input logic [63:0] er,
                       input logic en, ez, ee);
    opcode = op; a = ia; b = ib; c = ic; d = id; start = 1'b1;
    if (push) sb.push_back('{tag, cyc + lat, er, en, ez, ee});
    if (lat > 1) st_q.push_back('{{tag, "_busy"}, cyc + 1, 1'b0, 1'b0, last_res, last_n, last_z, last_e});
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      last_res = er; last_n = en; last_z = ez; last_e = ee;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] ia, ib, ic, id,
                        input logic [63:0] er, input logic en, ez);
    issue(tag, op, ia, ib, ic, id, 1'b1, 9, er, en, ez, 1'b0);
    repeat (9) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0; c = '0; d = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    st_q.push_back('{"reset", cyc + 1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // mul 7*6 with a start pulse mid-run that must be ignored
    issue("mul7x6", 4'b0000, 32'd7, 32'd6, 32'd0, 32'd0, 1'b1, 9, 64'd42, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    start = 1'b1; opcode = 4'b0100; a = 32'd100; b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    run_op("umull_max", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
    run_op("smull_m3x5", 4'b0110, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0);
    run_op("smlal_zero", 4'b0111, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'd15, 64'h0, 1'b0, 1'b1);
    run_op("umlal_wrap", 4'b0101, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 1'b0, 1'b1);
    run_op("smull_minsq", 4'b0110, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    run_op("mla_trunc", 4'b0001, 32'h0001_0000, 32'h0001_0000, 32'd5, 32'h0, 64'd5, 1'b0, 1'b0);
    run_op("mul_neg_short", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    run_op("mul_zero_short", 4'b0000, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 64'h0, 1'b0, 1'b1);
    run_op("smlal_negneg", 4'b0111, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd1, 64'd7, 1'b0, 1'b0);
    run_op("umull_shift", 4'b0100, 32'h1234_5678, 32'h10, 32'h0, 32'h0, 64'h0000_0001_2345_6780, 1'b0, 1'b0);

    // mla aborted by reset; starts during RUN and alongside rst are ignored
    issue("mla_abort", 4'b0001, 32'd9, 32'd9, 32'd1, 32'd0, 1'b0, 9, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    start = 1'b1; opcode = 4'b0000; a = 32'd55; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; opcode = 4'b0000; a = 32'd3; b = 32'd3;
    st_q.push_back('{"abort_idle", cyc + 1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    last_res = '0; last_n = 1'b0; last_z = 1'b0; last_e = 1'b0;
    repeat (6) @(negedge clk);
    run_op("mul2x3", 4'b0000, 32'd2, 32'd3, 32'h0, 32'h0, 64'd6, 1'b0, 1'b0);

    // unsupported opcode, then back-to-back mul accepted on its done cycle
    issue("bad_op", 4'b0010, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1, 64'h0, 1'b0, 1'b0, 1'b1);
    issue("b2b_mul4x4", 4'b0000, 32'd4, 32'd4, 32'h0, 32'h0, 1'b1, 9, 64'd16, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);

    finish_req = 1'b1;
  end

endmodule

// File: doc/multiply_accumulate_unit.md
MULTIPLY_ACCUMULATE_UNIT -- requirements
Module: multiply_accumulate_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
REQ-002 WIDTH, 32, operand width in bits.
REQ-003 STEP, 4, multiplier bits retired per cycle; WIDTH SHALL be a multiple of STEP.
REQ-004 Ports SHALL be, one per line: name, direction, width, meaning.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request; accepted only when ready=1.
REQ-008 opcode  input  4  0000 mul, 0001 mla, 0100 umull, 0101 umlal, 0110 smull, 0111 smlal.
REQ-009 a, b  input  WIDTH each  multiplicand, multiplier.
REQ-010 c, d  input  WIDTH each  accumulator; mla uses c; long ops use {c,d}, with c as the high word.
REQ-011 ready  output  1  high when idle or when done=1.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 result  output  2*WIDTH  product or accumulate result.
REQ-014 flag_n, flag_z  output  1 each  sign and zero of the result.
REQ-015 err  output  1  valid with done; set when opcode is unsupported.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE or DONE with start=1 SHALL latch opcode, a, b, c and d, then enter RUN; ready SHALL be 0 the next cycle.
REQ-018 start while ready=0 SHALL be ignored, with no effect on the operation in flight.
REQ-019 RUN SHALL last exactly WIDTH/STEP cycles, adding STEP partial-product bits per cycle under an iteration counter.
REQ-020 After the last RUN cycle the block SHALL enter DONE: done=1 for one cycle, exactly WIDTH/STEP+1 cycles after the accept edge.
REQ-021 DONE SHALL return to IDLE unless start=1, in which case the new request SHALL be accepted back-to-back.
REQ-022 mul SHALL return result = zero-extended (a*b) mod 2^WIDTH.
REQ-023 mla SHALL return result = zero-extended (a*b+c) mod 2^WIDTH.
REQ-024 umull SHALL return result = a*b, unsigned, full 2*WIDTH bits.
REQ-025 umlal SHALL return result = (a*b+{c,d}) mod 2^(2*WIDTH), with carry-out discarded.
REQ-026 smull and smlal SHALL use signed a and b: magnitudes are multiplied, the product is negated when the signs differ, and smlal then adds {c,d} mod 2^(2*WIDTH).
REQ-027 smull of the most-negative value by itself SHALL give 2^(2*WIDTH-2) exactly.
REQ-028 For short ops (mul, mla), flag_n SHALL be result[WIDTH-1]; for long ops it SHALL be result[2*WIDTH-1].
REQ-029 flag_z SHALL be 1 iff the relevant width of result is all zero.
REQ-030 An unsupported opcode SHALL skip RUN: done=1 on the cycle after accept, with err=1, result=0 and flags 0.
REQ-031 result, flags and err SHALL hold from done until the next accept and SHALL be unchanged during RUN.

Reset
REQ-032 rst=1 SHALL force IDLE, with ready=1, done=0, err=0, result=0, flag_n=0, flag_z=0 and counter=0 after the edge.
REQ-033 rst asserted during RUN SHALL abort the operation with no done pulse; start in the same cycle as rst SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the FSM state enum and the long/short opcode classification function.
REQ-035 One combinational sub-module, mac_step, SHALL add STEP multiplier bits times the multiplicand into the running 2*WIDTH sum.
REQ-036 The block SHALL be instantiable by the control unit in place of the combinational multiply path.

Verification
REQ-037 With WIDTH=32 and STEP=4, mul a=7, b=6 accepted at cycle 0 -> done at cycle 9, result=42, flag_z=0, err=0.
REQ-038 umull a=b=0xFFFFFFFF -> result=0xFFFFFFFE_00000001, flag_n=1.
REQ-039 smull a=-3, b=5 -> result=0xFFFFFFFF_FFFFFFF1, flag_n=1; smlal with the same a, b and {c,d}=15 -> result=0, flag_z=1.
REQ-040 umlal a=1, b=1, {c,d}=0xFFFFFFFF_FFFFFFFF -> result=0 (wrap), flag_z=1.
REQ-041 mla accepted at cycle 0, start pulsed at cycle 3, rst at cycle 5 -> no done, ready=1 at cycle 6, all outputs 0; a following mul 2*3 -> result 6.
REQ-042 opcode 0010 -> done at cycle 1, err=1, result=0; a back-to-back mul 4*4 started while done=1 -> done 9 cycles later, result=16.
